// File: rtl/pixel_streamer.sv
// pixel_streamer
//   Frame source feeding the 8-bit pixel input of the Sobel stage. A host
//   loads one COLS x ROWS frame into an internal buffer while idle; on start
//   the frame is streamed in raster order with a valid/ready handshake, then
//   frame_done pulses and the block either idles or replays the frame.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   wr_en       frame-buffer write strobe (honoured only while idle)
//   wr_addr     raster index to write
//   wr_data     pixel byte to write
//   start       begin streaming (sampled only while idle)
//   repeat_en   replay the frame after DONE instead of idling
//   fill_now    downstream ready; transfer when fill_now && data_valid
//   Dout        registered pixel byte
//   data_valid  Dout holds a valid pixel
//   busy        high in every state except IDLE
//   frame_done  one-cycle pulse after the last pixel transfers
//   state       FSM state: IDLE=00, STREAM=01, DONE=10
module pixel_streamer #(
  parameter int COLS   = 5,
  parameter int ROWS   = 5,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              start,
  input  logic              repeat_en,
  input  logic              fill_now,
  output logic [7:0]        Dout,
  output logic              data_valid,
  output logic              busy,
  output logic              frame_done,
  output logic [1:0]        state
);

  localparam int                DATA_W = 8;
  localparam int                PIX    = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(PIX - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STREAM = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic        [DATA_W-1:0]   r_mem [0:PIX-1];
  logic        [ADDR_W-1:0]   r_ptr;
  logic        [ADDR_W-1:0]   w_ptr_nxt;
  logic        [ADDR_W-1:0]   w_ptr_inc;
  logic        [DATA_W-1:0]   r_dout;
  logic        [DATA_W-1:0]   w_dout_nxt;
  logic                       r_vld;
  logic                       w_vld_nxt;
  logic                       w_wr_ok;

  // Widened compare so the range check still works when PIX == 2^ADDR_W.
  assign w_wr_ok   = (r_state == ST_IDLE) && wr_en &&
                     ({1'b0, wr_addr} < (ADDR_W + 1)'(PIX));
  assign w_ptr_inc = r_ptr + ADDR_W'(1);

  // Frame buffer: no reset, contents survive rst. A write coinciding with
  // start lands after the nonblocking read of mem[0], so the new byte first
  // appears on the following frame.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_dout  <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_dout  <= w_dout_nxt;
      r_vld   <= w_vld_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_dout_nxt  = r_dout;
    w_vld_nxt   = r_vld;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_ptr_nxt   = '0;
          w_dout_nxt  = r_mem[0];
          w_vld_nxt   = 1'b1;
          w_state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        // Without fill_now everything holds, keeping Dout stable.
        if (fill_now) begin
          if (r_ptr == LAST) begin
            w_vld_nxt   = 1'b0;
            w_dout_nxt  = '0;
            w_state_nxt = ST_DONE;
          end else begin
            w_ptr_nxt  = w_ptr_inc;
            w_dout_nxt = r_mem[w_ptr_inc];
          end
        end
      end
      ST_DONE: begin
        if (repeat_en) begin
          w_ptr_nxt   = '0;
          w_dout_nxt  = r_mem[0];
          w_vld_nxt   = 1'b1;
          w_state_nxt = ST_STREAM;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_vld_nxt   = 1'b0;
        w_dout_nxt  = '0;
      end
    endcase
  end

  assign Dout       = r_dout;
  assign data_valid = r_vld;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = (r_state == ST_DONE);
  assign state      = r_state;

endmodule

// File: doc/pixel_streamer.md
# pixel_streamer

Frame source that drives the 8-bit pixel input of the Sobel filter stage. A host first loads one frame of COLS x ROWS bytes into an internal frame buffer. On `start`, the block streams the frame out in raster order on `Dout`/`data_valid`, and stalls whenever the downstream stage deasserts `fill_now`. At end of frame it pulses `frame_done`, then either returns to idle or restarts the same frame if `repeat` is set.

## Interface
Parameters:
- COLS, 5, pixels per line
- ROWS, 5, lines per frame
- ADDR_W, 5, frame-buffer address width; must satisfy 2^ADDR_W >= COLS*ROWS

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  frame-buffer write strobe
- wr_addr  in  ADDR_W  write address (raster index)
- wr_data  in  8  pixel byte to write
- start  in  1  begin streaming the frame (level sampled in IDLE)
- repeat  in  1  restart the frame after DONE instead of idling
- fill_now  in  1  downstream ready; a transfer occurs when this is 1 and `data_valid` is 1
- Dout  out  8  pixel byte, registered
- data_valid  out  1  `Dout` holds a valid pixel
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last pixel transfers
- state  out  2  FSM state: IDLE=00, STREAM=01, DONE=10; 11 is unused

## Operation
- PIX = COLS*ROWS. The frame buffer is a reg array of PIX bytes and is not cleared by reset.
- Writes:
  - Accepted only in IDLE, when `wr_en`=1 and `wr_addr` < PIX.
  - Writes in any other state, or to out-of-range addresses, are ignored.
- Read pointer `ptr` (ADDR_W bits) holds the raster index of the pixel currently on `Dout`.
- IDLE:
  - Outputs: `data_valid`=0, `busy`=0.
  - If `start`=1: `Dout`<=mem[0], `ptr`<=0, `data_valid`<=1, go to STREAM.
  - If `wr_en` and `start` are both high on the same edge, the write is performed and streaming begins. The new byte must not reach `Dout` before the next read of that address.
- STREAM:
  - If `fill_now`=0: `Dout`, `data_valid` and `ptr` hold.
  - If `fill_now`=1 and `ptr` < PIX-1: `ptr`<=`ptr`+1 and `Dout`<=mem[`ptr`+1], with `data_valid` kept at 1. Throughput is one pixel per cycle with no bubbles.
  - If `fill_now`=1 and `ptr`=PIX-1: `data_valid`<=0, `Dout`<=0, go to DONE.
- DONE:
  - `frame_done`=1 for exactly this cycle.
  - If `repeat`=1: `ptr`<=0, `Dout`<=mem[0], `data_valid`<=1, go to STREAM.
  - Otherwise go to IDLE.
- `start` is ignored outside IDLE.
- `fill_now` is ignored outside STREAM.
- Pointer wrap to 0 happens only via DONE, never by counter overflow.

## Timing
- Reset (asynchronous, immediate): `state`=IDLE, `Dout`=0, `data_valid`=0, `busy`=0, `frame_done`=0, `ptr`=0.
- Reset mid-frame aborts the frame immediately. The next frame restarts at pixel 0 after a new `start`.
- Start latency: with `start` sampled at edge t, `data_valid`=1 and `Dout`=mem[0] from t+1.
- With `fill_now` held at 1: transfers occur at edges t+1 .. t+PIX; `frame_done` is high during the cycle after edge t+PIX; `state` is IDLE from edge t+PIX+1.
- `Dout` is stable for as long as `data_valid`=1 and no transfer has occurred.
- With `repeat`=1 and `fill_now`=1 there is exactly one non-valid cycle (DONE) between frames.
- `frame_done` and `data_valid` are never high in the same cycle.

## Test plan
- Load mem[i]=i+1 for i=0..24, pulse `start`, hold `fill_now`=1 -> Dout sequence 1..25 on 25 consecutive cycles, `frame_done` pulses once on the following cycle, then IDLE.
- Same frame with `fill_now` low for 3 cycles while Dout=7 -> Dout stays 7 with `data_valid`=1 for those cycles, next transfer gives 8, no pixel lost or duplicated, 25 transfers total.
- Write to address 30, and `wr_en` during STREAM with wr_data=0xFF to address 0 -> neither changes the buffer; next frame still begins with 1.
- `repeat`=1 for two frames -> 1..25, one gap cycle with `frame_done`=1, 1..25 again; `start` pulses during STREAM have no effect.
- Assert `rst` at pixel 12 -> all outputs 0 and `state`=00 immediately; after `start` the stream begins at 1.
- `start` together with `wr_en` to addr 0 (0xAA) in IDLE -> stream starts and the next frame shows 0xAA as its first pixel.
